// File: rtl/branch_merge_8_if.sv
// Merge-side bus for branch_merge_8: eight unflow-controlled branch inputs,
// one valid/ready merged output plus status.
interface branch_merge_8_if #(
  parameter int unsigned WIDTH = 16
);
  logic [WIDTH-1:0] i_data_0, i_data_1, i_data_2, i_data_3;
  logic [WIDTH-1:0] i_data_4, i_data_5, i_data_6, i_data_7;
  logic             i_valid_0, i_valid_1, i_valid_2, i_valid_3;
  logic             i_valid_4, i_valid_5, i_valid_6, i_valid_7;
  logic [WIDTH-1:0] o_data;
  logic [2:0]       o_branch;
  logic             o_valid;
  logic             i_ready;
  logic [7:0]       o_overflow;
  logic             o_empty;

  modport slave (
    input  i_data_0, i_data_1, i_data_2, i_data_3,
    input  i_data_4, i_data_5, i_data_6, i_data_7,
    input  i_valid_0, i_valid_1, i_valid_2, i_valid_3,
    input  i_valid_4, i_valid_5, i_valid_6, i_valid_7,
    input  i_ready,
    output o_data, o_branch, o_valid, o_overflow, o_empty
  );

  modport master (
    output i_data_0, i_data_1, i_data_2, i_data_3,
    output i_data_4, i_data_5, i_data_6, i_data_7,
    output i_valid_0, i_valid_1, i_valid_2, i_valid_3,
    output i_valid_4, i_valid_5, i_valid_6, i_valid_7,
    output i_ready,
    input  o_data, o_branch, o_valid, o_overflow, o_empty
  );
endinterface

// File: rtl/branch_merge_8.sv
// Buffers eight branch streams in private FIFOs and merges them round-robin into one
// valid/ready stream tagged with the branch index; drops are flagged sticky per branch.
module branch_merge_8 #(
   parameter int unsigned WIDTH = 16,
   parameter int unsigned DEPTH = 4
) (
   input logic          i_clock,
   input logic          i_reset_n,
   branch_merge_8_if.slave bus
);
   localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int unsigned CW = $clog2(DEPTH) + 1;

   logic [WIDTH-1:0] mem_q [8][DEPTH];
   logic [AW-1:0]    wr_ptr_q [8], wr_ptr_d [8];
   logic [AW-1:0]    rd_ptr_q [8], rd_ptr_d [8];
   logic [CW-1:0]    cnt_q [8], cnt_d [8];
   logic [WIDTH-1:0] in_data [8];
   logic [7:0]       in_valid;
   logic [7:0]       push, pop;
   logic [2:0]       rr_q, rr_d, sel, idx;
   logic             found, can_load;
   logic [WIDTH-1:0] out_data_q, out_data_d;
   logic [2:0]       out_branch_q, out_branch_d;
   logic             out_valid_q, out_valid_d;
   logic [7:0]       overflow_q, overflow_d;
   logic             empty_q, empty_d;

   assign in_data[0] = bus.i_data_0;
   assign in_data[1] = bus.i_data_1;
   assign in_data[2] = bus.i_data_2;
   assign in_data[3] = bus.i_data_3;
   assign in_data[4] = bus.i_data_4;
   assign in_data[5] = bus.i_data_5;
   assign in_data[6] = bus.i_data_6;
   assign in_data[7] = bus.i_data_7;
   assign in_valid = {bus.i_valid_7, bus.i_valid_6, bus.i_valid_5, bus.i_valid_4,
                      bus.i_valid_3, bus.i_valid_2, bus.i_valid_1, bus.i_valid_0};

   always_comb begin
      can_load     = !out_valid_q || bus.i_ready;
      found        = 1'b0;
      sel          = '0;
      idx          = '0;
      pop          = '0;
      push         = '0;
      out_valid_d  = out_valid_q;
      out_data_d   = out_data_q;
      out_branch_d = out_branch_q;
      rr_d         = rr_q;
      // Scan uses occupancy before this edge's pushes, starting at the rr pointer.
      for (int i = 0; i < 8; i++) begin
         idx = rr_q + 3'(i);
         if (!found && cnt_q[idx] != '0) begin
            found = 1'b1;
            sel   = idx;
         end
      end
      if (can_load) begin
         out_valid_d = found;
         if (found) begin
            pop[sel]     = 1'b1;
            out_data_d   = mem_q[sel][rd_ptr_q[sel]];
            out_branch_d = sel;
            rr_d         = sel + 3'd1;
         end
      end
      for (int k = 0; k < 8; k++) begin
         // A full FIFO still takes a word when it is popped on the same edge.
         push[k]     = in_valid[k] && (cnt_q[k] != CW'(DEPTH) || pop[k]);
         wr_ptr_d[k] = wr_ptr_q[k] + AW'(push[k]);
         rd_ptr_d[k] = rd_ptr_q[k] + AW'(pop[k]);
         cnt_d[k]    = cnt_q[k] + CW'(push[k]) - CW'(pop[k]);
      end
      overflow_d = overflow_q | (in_valid & ~push);
      empty_d    = !out_valid_d;
      for (int k = 0; k < 8; k++) begin
         if (cnt_d[k] != '0) empty_d = 1'b0;
      end
   end

   always_ff @(posedge i_clock) begin
      for (int k = 0; k < 8; k++) begin
         if (push[k]) mem_q[k][wr_ptr_q[k]] <= in_data[k];
      end
   end

   always_ff @(posedge i_clock or negedge i_reset_n) begin
      if (!i_reset_n) begin
         for (int k = 0; k < 8; k++) begin
            wr_ptr_q[k] <= '0;
            rd_ptr_q[k] <= '0;
            cnt_q[k]    <= '0;
         end
         rr_q         <= '0;
         out_data_q   <= '0;
         out_branch_q <= '0;
         out_valid_q  <= 1'b0;
         overflow_q   <= '0;
         empty_q      <= 1'b1;
      end else begin
         for (int k = 0; k < 8; k++) begin
            wr_ptr_q[k] <= wr_ptr_d[k];
            rd_ptr_q[k] <= rd_ptr_d[k];
            cnt_q[k]    <= cnt_d[k];
         end
         rr_q         <= rr_d;
         out_data_q   <= out_data_d;
         out_branch_q <= out_branch_d;
         out_valid_q  <= out_valid_d;
         overflow_q   <= overflow_d;
         empty_q      <= empty_d;
      end
   end

   assign bus.o_data     = out_data_q;
   assign bus.o_branch   = out_branch_q;
   assign bus.o_valid    = out_valid_q;
   assign bus.o_overflow = overflow_q;
   assign bus.o_empty    = empty_q;
endmodule

// File: tb/tb_branch_merge_8.sv
// Directed bench for branch_merge_8: cycle tables for fan-in and fairness, hand-written
// sequences for reset, overflow, full-FIFO push-with-pop and asynchronous reset.
module tb_branch_merge_8;
   typedef struct packed {
      logic [7:0]       valid;
      logic [7:0][15:0] data;
      logic             ready;
      logic             ev;
      logic [2:0]       eb;
      logic [15:0]      ed;
      logic [7:0]       eovf;
      logic             ee;
   } vec_t;

   logic clk = 1'b0;
   logic rst_n = 1'b1;
   int   n_tests = 0;
   int   n_fail = 0;
   vec_t tbl [20];

   branch_merge_8_if #(.WIDTH(16)) bus ();

   branch_merge_8 #(.WIDTH(16), .DEPTH(4)) dut (
      .i_clock   (clk),
      .i_reset_n (rst_n),
      .bus       (bus.slave)
   );

   always #5 clk = ~clk;

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic set_in(input logic [7:0] v, input logic [7:0][15:0] d, input logic r);
      bus.i_valid_0 = v[0]; bus.i_valid_1 = v[1]; bus.i_valid_2 = v[2]; bus.i_valid_3 = v[3];
      bus.i_valid_4 = v[4]; bus.i_valid_5 = v[5]; bus.i_valid_6 = v[6]; bus.i_valid_7 = v[7];
      bus.i_data_0 = d[0]; bus.i_data_1 = d[1]; bus.i_data_2 = d[2]; bus.i_data_3 = d[3];
      bus.i_data_4 = d[4]; bus.i_data_5 = d[5]; bus.i_data_6 = d[6]; bus.i_data_7 = d[7];
      bus.i_ready = r;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic push_one(input int br, input logic [15:0] val, input logic r);
      logic [7:0]       v;
      logic [7:0][15:0] d;
      v = '0;
      d = '0;
      v[br] = 1'b1;
      d[br] = val;
      set_in(v, d, r);
   endtask

   initial begin
      logic [7:0][15:0] zd;
      logic [7:0][15:0] rd;
      zd = '0;
      set_in(8'h00, zd, 1'b0);

      // Fan-in: all branches in one cycle, then eight words in branch order.
      for (int i = 0; i < 20; i++) tbl[i] = '0;
      for (int i = 0; i < 20; i++) tbl[i].ready = 1'b1;
      tbl[0].valid = 8'hff;
      for (int k = 0; k < 8; k++) tbl[0].data[k] = 16'(k);
      tbl[0].ee = 1'b1;
      for (int i = 2; i < 10; i++) begin
         tbl[i].ev = 1'b1;
         tbl[i].eb = 3'(i - 2);
         tbl[i].ed = 16'(i - 2);
      end
      tbl[10].ee = 1'b1;
      // Fairness: branches 0 and 5 together for three cycles.
      for (int j = 0; j < 3; j++) begin
         tbl[11 + j].valid   = 8'b0010_0001;
         tbl[11 + j].data[0] = 16'h0100 + 16'(j);
         tbl[11 + j].data[5] = 16'h0500 + 16'(j);
      end
      tbl[11].ee = 1'b1;
      for (int j = 0; j < 6; j++) begin
         tbl[13 + j].ev = 1'b1;
         tbl[13 + j].eb = (j % 2 == 0) ? 3'd0 : 3'd5;
         tbl[13 + j].ed = ((j % 2 == 0) ? 16'h0100 : 16'h0500) + 16'(j / 2);
      end
      tbl[19].ee = 1'b1;

      // Reset held with toggling inputs.
      #1 rst_n = 1'b0;
      #1;
      for (int c = 0; c < 6; c++) begin
         for (int k = 0; k < 8; k++) rd[k] = 16'($urandom);
         set_in(8'($urandom), rd, 1'($urandom));
         #2;
         check("rst_valid", 32'(bus.o_valid), 0);
         check("rst_data", 32'(bus.o_data), 0);
         check("rst_branch", 32'(bus.o_branch), 0);
         check("rst_ovf", 32'(bus.o_overflow), 0);
         check("rst_empty", 32'(bus.o_empty), 1);
         tick();
      end
      set_in(8'h00, zd, 1'b0);
      rst_n = 1'b1;

      for (int i = 0; i < 20; i++) begin
         set_in(tbl[i].valid, tbl[i].data, tbl[i].ready);
         check($sformatf("tbl%0d_valid", i), 32'(bus.o_valid), 32'(tbl[i].ev));
         check($sformatf("tbl%0d_empty", i), 32'(bus.o_empty), 32'(tbl[i].ee));
         check($sformatf("tbl%0d_ovf", i), 32'(bus.o_overflow), 32'(tbl[i].eovf));
         if (tbl[i].ev) begin
            check($sformatf("tbl%0d_branch", i), 32'(bus.o_branch), 32'(tbl[i].eb));
            check($sformatf("tbl%0d_data", i), 32'(bus.o_data), 32'(tbl[i].ed));
         end
         tick();
      end

      // Backpressure and overflow on branch 3.
      for (int i = 0; i < 6; i++) begin
         push_one(3, 16'h0030 + 16'(i), 1'b0);
         if (i >= 2) begin
            check("stall_valid", 32'(bus.o_valid), 1);
            check("stall_data", 32'(bus.o_data), 32'h30);
         end
         tick();
      end
      set_in(8'h00, zd, 1'b0);
      check("stall_ovf3", 32'(bus.o_overflow), 32'h08);
      check("stall_hold", 32'(bus.o_data), 32'h30);
      set_in(8'h00, zd, 1'b1);
      for (int i = 0; i < 5; i++) begin
         check("drain_valid", 32'(bus.o_valid), 1);
         check("drain_data", 32'(bus.o_data), 32'h30 + 32'(i));
         check("drain_branch", 32'(bus.o_branch), 3);
         tick();
      end
      check("drain_done", 32'(bus.o_valid), 0);
      check("drain_ovf3", 32'(bus.o_overflow), 32'h08);
      check("drain_empty", 32'(bus.o_empty), 1);

      // Full FIFO on branch 2 accepts a push on the same edge it is popped.
      for (int i = 0; i < 5; i++) begin
         push_one(2, 16'h0020 + 16'(i), 1'b0);
         tick();
      end
      push_one(2, 16'h0025, 1'b1);
      check("full_head", 32'(bus.o_data), 32'h20);
      tick();
      set_in(8'h00, zd, 1'b1);
      for (int i = 1; i < 6; i++) begin
         check("full_valid", 32'(bus.o_valid), 1);
         check("full_data", 32'(bus.o_data), 32'h20 + 32'(i));
         tick();
      end
      check("full_done", 32'(bus.o_valid), 0);
      check("full_ovf2", 32'(bus.o_overflow[2]), 0);

      // Asynchronous reset with data buffered and the output register loaded.
      for (int i = 0; i < 3; i++) begin
         push_one(1 + 5 * (i % 2), 16'h00a0 + 16'(i), 1'b0);
         tick();
      end
      set_in(8'h00, zd, 1'b0);
      tick();
      check("pre_arst_valid", 32'(bus.o_valid), 1);
      #3 rst_n = 1'b0;
      #1;
      check("arst_valid", 32'(bus.o_valid), 0);
      check("arst_empty", 32'(bus.o_empty), 1);
      check("arst_data", 32'(bus.o_data), 0);
      check("arst_ovf", 32'(bus.o_overflow), 0);
      tick();
      rst_n = 1'b1;
      set_in(8'h00, zd, 1'b1);
      for (int i = 0; i < 4; i++) begin
         tick();
         check("post_arst_valid", 32'(bus.o_valid), 0);
         check("post_arst_empty", 32'(bus.o_empty), 1);
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule

// File: doc/branch_merge_8.md
# branch_merge_8

Downstream companion to the 8-branch MIMO FIFO. It accepts the eight per-branch output streams (data plus per-branch valid, no backpressure toward the source). It buffers each branch in a small private FIFO and merges them into one valid/ready stream tagged with the branch index, using round-robin arbitration. Branch overflow is flagged, never silent.

## Interface
- WIDTH, 16, data word width
- DEPTH, 4, per-branch FIFO depth in words; power of two, >= 2

- i_clock  in  1  rising-edge clock
- i_reset_n  in  1  asynchronous active-low reset
- i_data_0 .. i_data_7  in  WIDTH each  branch k input word
- i_valid_0 .. i_valid_7  in  1 each  branch k word present this cycle
- o_data  out  WIDTH  merged output word
- o_branch  out  3  branch index of o_data
- o_valid  out  1  o_data/o_branch valid
- i_ready  in  1  downstream accepts when o_valid & i_ready at rising edge
- o_overflow  out  8  sticky per-branch drop flag
- o_empty  out  1  all FIFOs and output register empty

## Operation
- Per-branch FIFO k, depth DEPTH. Push when i_valid_k=1 at the edge.
- Push into a full FIFO is accepted only if that FIFO is popped on the same edge. Otherwise the word is dropped and o_overflow[k] is set, staying set until reset.
- Single output register holds o_data/o_branch/o_valid. It can load when empty (o_valid=0) or being consumed (o_valid & i_ready).
- Arbiter: round-robin pointer rr (3 bits, reset 0).
  - When the output register can load, scan branches rr, rr+1, ... mod 8 and select the first non-empty FIFO (occupancy before this edge's pushes).
  - Pop that FIFO, load word and index into the output register, set rr = selected+1 mod 8.
  - If no FIFO is non-empty, o_valid goes 0 (if consumed) and rr is unchanged.
- Within a branch, word order is preserved. Across branches, order is round-robin only.
- With o_valid=1 and i_ready=0, o_data/o_branch/o_valid hold stable.
- Throughput: one word per cycle when i_ready=1 and any FIFO is non-empty.
- o_empty=1 iff every FIFO occupancy is 0 and o_valid=0. It is registered with the state.
- Occupancy counters are $clog2(DEPTH)+1 bits. Read/write pointers wrap modulo DEPTH.

## Timing
- Reset (i_reset_n=0, asynchronous, no clock needed) forces:
  - o_valid=0, o_data=0, o_branch=0, o_overflow=0, o_empty=1
  - all FIFOs empty, rr=0
- Leaving reset is synchronous to the next rising edge after deassertion.
- Latency: a word presented in cycle c (sampled at the edge ending c) is visible in its FIFO in cycle c+1. At the earliest it appears on o_data with o_valid=1 in cycle c+2.
- Reset mid-operation discards all buffered and output-register words immediately. No partial output follows.
- Simultaneous push and pop on the same FIFO: occupancy unchanged, both succeed.
- All eight branches valid in one cycle with all FIFOs non-full: all eight are accepted.

## Test plan
- Reset: hold i_reset_n=0 with random inputs toggling -> o_valid=0, o_data=0, o_branch=0, o_overflow=8'h00, o_empty=1 throughout.
- Fan-in:
  - Stimulus: one cycle with i_valid_k=1 and i_data_k=k for k=0..7; i_ready=1.
  - Required: o_valid first high 2 cycles later, then eight consecutive words with o_branch=0..7 in order and o_data==o_branch. o_empty=1 after, o_overflow=0.
- Backpressure/overflow (DEPTH=4):
  - Stimulus: i_ready=0; branch 3 receives 0x30..0x35 on six consecutive cycles.
  - Required while stalled: o_data=0x30 held stable with o_valid=1; o_overflow[3]=1.
  - Required after raising i_ready: outputs 0x30,0x31,0x32,0x33,0x34 then o_valid=0. 0x35 never appears; o_overflow[3] stays 1.
- Fairness: branches 0 and 5 each receive 3 words in the same 3 cycles, i_ready=1 -> o_branch sequence 0,5,0,5,0,5 with per-branch data order preserved.
- Full-FIFO push with pop:
  - Stimulus: fill branch 2 to DEPTH with i_ready=0; raise i_ready; push one more word to branch 2 on the first consuming edge.
  - Required: that word is accepted and output last, o_overflow[2]=0.
- Async reset mid-stream: with o_valid=1 and words buffered, drive i_reset_n low between edges -> o_valid falls before the next edge. After release, no words are output and o_empty=1.
